// File: rtl/mux_seq.sv
// Registered N:1 channel mux with direct-select and round-robin scan modes.
// Output beat uses a valid/ready handshake and flags out-of-range selects.
module mux_seq #(
  parameter int WIDTH      = 2,
  parameter int NUM_INPUTS = 31,
  parameter int SEL_W      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_INPUTS*WIDTH-1:0] inp_bus,
  input  logic [NUM_INPUTS-1:0]       chan_en,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_valid,
  output logic                        sel_err
);

  typedef enum logic {DIRECT, SCAN} state_t;

  state_t           state, nxt_state;
  logic [SEL_W-1:0] ptr, nxt_ptr;
  logic             first, nxt_first;
  logic [WIDTH-1:0] nxt_data;
  logic [SEL_W-1:0] nxt_sel;
  logic             nxt_valid, nxt_err;

  logic [WIDTH-1:0] ch [NUM_INPUTS];
  logic             load;
  logic             origin_incl;
  logic             hit;
  int               hit_idx;
  int               start;
  int               j;
  int               sel_i;

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_ch
    assign ch[k] = inp_bus[k*WIDTH +: WIDTH];
  end

  assign load        = !out_valid | out_ready;
  assign origin_incl = (state == DIRECT) | first;
  assign sel_i       = int'(sel);

  // First enabled channel at or after the search origin, wrapping.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    j       = 0;
    start   = 0;
    if (!origin_incl)
      start = (int'(ptr) + 1 >= NUM_INPUTS) ? 0 : int'(ptr) + 1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      j = start + i;
      if (j >= NUM_INPUTS)
        j = j - NUM_INPUTS;
      if (!hit && chan_en[j]) begin
        hit     = 1'b1;
        hit_idx = j;
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_first = first;
    nxt_data  = out_data;
    nxt_sel   = out_sel;
    nxt_valid = out_valid;
    nxt_err   = sel_err;
    if (load) begin
      unique case (1'b1)
        !mode: begin
          nxt_state = DIRECT;
          nxt_valid = 1'b1;
          nxt_sel   = sel;
          if (sel_i < NUM_INPUTS) begin
            nxt_data = ch[sel_i];
            nxt_err  = 1'b0;
          end else begin
            nxt_data = '0;
            nxt_err  = 1'b1;
          end
        end
        mode: begin
          nxt_state = SCAN;
          if (state == DIRECT)
            nxt_ptr = '0;
          if (hit) begin
            nxt_data  = ch[hit_idx];
            nxt_sel   = SEL_W'(hit_idx);
            nxt_err   = 1'b0;
            nxt_valid = 1'b1;
            nxt_ptr   = SEL_W'(hit_idx);
            nxt_first = 1'b0;
          end else begin
            // Nothing enabled: keep the origin so the next search is unchanged.
            nxt_valid = 1'b0;
            nxt_err   = 1'b0;
            nxt_first = origin_incl;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DIRECT;
      ptr       <= '0;
      first     <= 1'b1;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state     <= nxt_state;
      ptr       <= nxt_ptr;
      first     <= nxt_first;
      out_data  <= nxt_data;
      out_sel   <= nxt_sel;
      out_valid <= nxt_valid;
      sel_err   <= nxt_err;
    end
  end

endmodule

// File: tb/tb_mux_seq.sv
// Bench for mux_seq: directed vectors with literal expectations plus a
// beat-level reference model compared on every falling edge.
module tb_mux_seq;

  localparam int W  = 2;
  localparam int N  = 31;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  inp_bus;
  logic [N-1:0]    chan_en;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            sel_err;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  mux_seq #(.WIDTH(W), .NUM_INPUTS(N), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .inp_bus(inp_bus), .chan_en(chan_en), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Reference model: the beat the consumer should be seeing.
  int m_data, m_sel, m_valid, m_err;
  bit m_scan, m_first;
  int m_ptr;

  function automatic int chan(int k);
    return int'(inp_bus[k*W +: W]);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_data = 0; m_sel = 0; m_valid = 0; m_err = 0;
      m_scan = 0; m_first = 1; m_ptr = 0;
    end else if (m_valid == 0 || out_ready) begin
      if (!mode) begin
        m_scan  = 0;
        m_valid = 1;
        m_sel   = int'(sel);
        m_err   = (int'(sel) >= N) ? 1 : 0;
        m_data  = m_err ? 0 : chan(int'(sel));
      end else begin
        int from;
        bit got;
        if (!m_scan) begin
          m_scan = 1; m_first = 1; m_ptr = 0;
        end
        from = m_first ? 0 : (m_ptr + 1) % N;
        got = 0;
        for (int o = 0; o < N; o++) begin
          int k;
          k = (from + o) % N;
          if (!got && chan_en[k]) begin
            got = 1; m_ptr = k; m_first = 0;
            m_valid = 1; m_err = 0; m_sel = k; m_data = chan(k);
          end
        end
        if (!got) begin
          m_valid = 0; m_err = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      tests++;
      if (int'(out_valid) != m_valid ||
          (m_valid != 0 && (int'(out_data) != m_data ||
           int'(out_sel) != m_sel || int'(sel_err) != m_err))) begin
        fails++;
        $display("FAIL model t=%0t got v=%0d d=%0d s=%0d e=%0d want v=%0d d=%0d s=%0d e=%0d",
                 $time, out_valid, out_data, out_sel, sel_err,
                 m_valid, m_data, m_sel, m_err);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic set_chan(int k, int v);
    inp_bus[k*W +: W] = W'(v);
  endtask

  initial begin
    reset = 1; mode = 0; sel = '0; chan_en = '0; out_ready = 1;
    for (int k = 0; k < N; k++) set_chan(k, k % 4);
    cyc();
    cyc();
    chk_on = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_err", sel_err, 0);
    reset = 0;

    // Direct sweep, including the one out-of-range select.
    for (int s = 0; s < 32; s++) begin
      sel = SW'(s);
      cyc();
      chk("sweep_sel", out_sel, s);
      chk("sweep_err", sel_err, s == 31 ? 1 : 0);
      chk("sweep_data", out_data, s == 31 ? 0 : s % 4);
      if (s == 12) chk("sel12_data", out_data, 0);
      if (s == 13) chk("sel13_data", out_data, 1);
    end
    chk("sel31_err", sel_err, 1);

    // Stall hold.
    set_chan(5, 3); sel = 5;
    cyc();
    chk("stall_pre", out_data, 3);
    out_ready = 0; sel = 6; set_chan(5, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_data", out_data, 3);
      chk("stall_sel", out_sel, 5);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1;
    cyc();
    chk("after_stall_sel", out_sel, 6);
    chk("after_stall_data", out_data, 2);
    set_chan(5, 1);

    // Round-robin over {2,7,30}.
    mode = 1; chan_en = '0;
    chan_en[2] = 1; chan_en[7] = 1; chan_en[30] = 1;
    cyc(); chk("rr0", out_sel, 2);  chk("rr0d", out_data, 2);
    cyc(); chk("rr1", out_sel, 7);  chk("rr1d", out_data, 3);
    cyc(); chk("rr2", out_sel, 30); chk("rr2d", out_data, 2);
    cyc(); chk("rr3", out_sel, 2);
    cyc(); chk("rr4", out_sel, 7);

    // Mode switch back to direct and then re-entry.
    mode = 0; sel = 3;
    cyc(); chk("sw_dir", out_sel, 3); chk("sw_dir_d", out_data, 3);
    mode = 1; chan_en = '0; chan_en[2] = 1; chan_en[7] = 1;
    cyc(); chk("sw_scan0", out_sel, 2);
    cyc(); chk("sw_scan1", out_sel, 7);

    // Empty and single-channel scan.
    chan_en = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("empty_valid", out_valid, 0);
    end
    chan_en[4] = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("single_sel", out_sel, 4); chk("single_v", out_valid, 1);
    end

    // Reset in the middle of a stalled beat.
    mode = 0; sel = 9;
    cyc();
    out_ready = 0;
    cyc(); chk("pre_rst_v", out_valid, 1);
    reset = 1;
    cyc();
    chk("mid_rst_v", out_valid, 0);
    chk("mid_rst_d", out_data, 0);
    chk("mid_rst_s", out_sel, 0);
    chk("mid_rst_e", sel_err, 0);
    reset = 0; out_ready = 1; mode = 1;
    chan_en = '0; chan_en[0] = 1; chan_en[3] = 1;
    cyc(); chk("post_rst0", out_sel, 0);
    cyc(); chk("post_rst1", out_sel, 3);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) chan_en = N'({$urandom, $urandom}) & N'({$urandom, $urandom});
      if ($urandom_range(0, 40) == 0) chan_en = '0;
      sel = SW'($urandom);
      inp_bus = {$urandom, $urandom};
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 0;
    cyc();
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_seq.md
Name: mux_seq

Overview:
- Parametrised, registered N:1 multiplexer; generalised successor to the team's fixed 31:1 2-bit combinational mux.
- Two modes:
  - Direct: the select input chooses the channel.
  - Scan: round-robin over enabled channels.
- Output is a registered beat with a valid/ready handshake and an out-of-range select flag. Sits between a bank of channel sources and a single downstream consumer.

Parameters:
- WIDTH, 2, bits per channel.
- NUM_INPUTS, 31, number of channels (2..256).
- SEL_W, 5, select width; must satisfy 2**SEL_W >= NUM_INPUTS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = direct select, 1 = round-robin scan.
- sel  input  SEL_W  channel index for direct mode.
- inp_bus  input  NUM_INPUTS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- chan_en  input  NUM_INPUTS  per-channel enable, used in scan mode only.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel in out_data.
- out_valid  output  1  out_data/out_sel/sel_err hold a beat.
- sel_err  output  1  beat came from an out-of-range direct select.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset and has priority over all other activity.
- Reset values: out_data=0, out_sel=0, out_valid=0, sel_err=0, scan pointer ptr=0, state=DIRECT.
- Load enable: load = !out_valid | out_ready.
  - Output registers update only on a clk edge with load=1.
  - When out_valid=1 and out_ready=0 (stall), all outputs hold exactly.
  - Inputs are ignored during a stall.
- Latency: 1 cycle. The beat reflects inp_bus/sel/chan_en sampled at the load edge.
- State machine: states DIRECT and SCAN.
  - mode is sampled only on load edges.
  - mode=1 in DIRECT: go to SCAN, clear ptr to 0, and set the search origin to "inclusive of 0" for the first beat.
  - mode=0 in SCAN: go to DIRECT. That edge already produces a direct beat.
- Direct beat (mode=0 at the load edge):
  - If sel < NUM_INPUTS: out_data=inp_bus[sel], out_sel=sel, sel_err=0, out_valid=1.
  - If sel >= NUM_INPUTS: out_data=0, out_sel=sel, sel_err=1, out_valid=1.
  - A beat is produced on every load edge, so back-to-back beats run at 1/cycle when out_ready=1.
- Scan beat (mode=1 at the load edge):
  - Search order:
    - First beat after entering SCAN: search from index 0 inclusive.
    - Later beats: search from ptr+1, wrapping NUM_INPUTS-1 -> 0.
  - Pick the first k with chan_en[k]=1. Output out_data=inp_bus[k], out_sel=k, sel_err=0, out_valid=1, and set ptr=k.
  - If chan_en is all zero: out_valid=0 and ptr holds.
  - Single enabled channel: the same channel repeats every beat.
  - chan_en changes take effect at the next load edge. A beat already held in a stall is unaffected.
  - sel is ignored in scan mode.
- Widths: sel is compared unsigned against NUM_INPUTS. out_data is zero-extended nowhere; channel width equals WIDTH exactly.
- Reset mid-stall: the beat is discarded and outputs return to reset values on that edge.

Test Plan:
- Direct sweep: reset, mode=0, out_ready=1, inp_bus channel k = k mod 4, sel=0..31 one per cycle.
  - For sel 0..30: each beat one cycle later has out_data = sel mod 4, out_sel=sel, sel_err=0.
  - For sel=31: out_data=0, sel_err=1.
  - Regression: sel=12 -> out_data=0, sel=13 -> out_data=1 (distinct channels).
- Stall hold: sel=5 (inp5=2'b11), then out_ready=0 for 3 cycles while sel=6 and inp5 changes to 2'b00 -> out_data=2'b11, out_sel=5, out_valid=1 for all 3 cycles; the beat for sel=6 appears 1 cycle after out_ready=1.
- Scan round-robin: mode=1, chan_en bits {2,7,30} set, out_ready=1 -> out_sel sequence 2,7,30,2,7 on consecutive cycles; out_data matches each channel.
- Scan empty/single: chan_en=0 -> out_valid=0 indefinitely. chan_en=bit 4 only -> out_sel=4 every cycle.
- Mode switch: in scan after emitting channel 7, set mode=0, sel=3 -> next beat out_sel=3. Then set mode=1 with chan_en {2,7} -> beats restart at out_sel=2.
- Reset: assert reset during a stalled beat (out_valid=1, out_ready=0) -> next edge out_valid=0, out_data=0, out_sel=0, sel_err=0. After release with mode=1, scan starts from channel 0.
